// File: rtl/image_loader_pkg.sv
// rtl/image_loader_pkg.sv - shared types, constants and helpers for the image loader
package image_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ROW,
        S_TERM,
        S_ERR
    } state_t;

    localparam logic [15:0] DIM_10   = 16'd10;
    localparam logic [15:0] DIM_12   = 16'd12;
    localparam logic [15:0] DIM_16   = 16'd16;
    localparam logic [15:0] SENTINEL = 16'h00FF;

    function automatic logic is_dim(input logic [15:0] d);
        return (d == DIM_10) || (d == DIM_12) || (d == DIM_16);
    endfunction

    // Keeps the low dim bits of a row beat; a 32-bit mask makes dim=16 fall out naturally.
    function automatic logic [15:0] mask_row(input logic [15:0] d, input logic [4:0] dim);
        logic [31:0] m;
        m = (32'd1 << dim) - 32'd1;
        return d & m[15:0];
    endfunction

endpackage

// File: rtl/image_loader_if.sv
// rtl/image_loader_if.sv - host beat stream, session control and SRAM write bus of the image loader
interface image_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              load_start;
    logic              load_done;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] sram_write_address;
    logic [DATA_W-1:0] sram_write_data;
    logic              sram_write_enable;
    logic              load_busy;
    logic              load_error;
    logic              run_o;

    modport master (
        output load_start, load_done, in_valid, in_data,
        input  in_ready, sram_write_address, sram_write_data, sram_write_enable,
        input  load_busy, load_error, run_o
    );

    modport slave (
        input  load_start, load_done, in_valid, in_data,
        output in_ready, sram_write_address, sram_write_data, sram_write_enable,
        output load_busy, load_error, run_o
    );
endinterface

// File: rtl/image_loader.sv
// rtl/image_loader.sv - loads header/row beats into the input SRAM and terminates with a sentinel
// IMAGE_LOADER_AUTORUN_EN: when defined, run_o pulses the cycle after the sentinel write.
module image_loader
    import image_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input logic           clk,
    input logic           reset_b,
    image_loader_if.slave lif
);

    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t            state, state_nx;
    // Extra top bit marks that the last SRAM word has already been written.
    logic [ADDR_W:0]   wr_addr, wr_addr_nx;
    logic [4:0]        dim, dim_nx;
    logic [4:0]        row_cnt, row_cnt_nx;
    logic              err, err_nx;
    logic              in_ready;
    logic              we_nx;
    logic [DATA_W-1:0] wd_nx;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_data_q;
    logic              sram_we_q;

    always_comb begin
        state_nx   = state;
        wr_addr_nx = wr_addr;
        dim_nx     = dim;
        row_cnt_nx = row_cnt;
        err_nx     = err;
        in_ready   = 1'b0;
        we_nx      = 1'b0;
        wd_nx      = '0;
        case (state)
            S_IDLE, S_ERR: begin
                if (lif.load_start) begin
                    state_nx   = S_HDR;
                    wr_addr_nx = '0;
                    err_nx     = 1'b0;
                end
            end
            S_HDR: begin
                in_ready = ~lif.load_done;
                if (lif.load_done) begin
                    state_nx = S_TERM;
                end else if (lif.in_valid) begin
                    if (!is_dim(lif.in_data) || wr_addr[ADDR_W]) begin
                        err_nx   = 1'b1;
                        state_nx = S_ERR;
                    end else begin
                        we_nx      = 1'b1;
                        wd_nx      = lif.in_data;
                        dim_nx     = lif.in_data[4:0];
                        row_cnt_nx = lif.in_data[4:0];
                        wr_addr_nx = wr_addr + 1'b1;
                        // A header in the last word always leaves rows pending.
                        if (wr_addr == LAST) begin
                            err_nx   = 1'b1;
                            state_nx = S_ERR;
                        end else begin
                            state_nx = S_ROW;
                        end
                    end
                end
            end
            S_ROW: begin
                in_ready = 1'b1;
                if (lif.load_done) begin
                    err_nx   = 1'b1;
                    state_nx = S_ERR;
                end else if (lif.in_valid) begin
                    we_nx      = 1'b1;
                    wd_nx      = mask_row(lif.in_data, dim);
                    row_cnt_nx = row_cnt - 5'd1;
                    wr_addr_nx = wr_addr + 1'b1;
                    if (wr_addr == LAST && row_cnt != 5'd1) begin
                        err_nx   = 1'b1;
                        state_nx = S_ERR;
                    end else if (row_cnt == 5'd1) begin
                        state_nx = S_HDR;
                    end
                end
            end
            S_TERM: begin
                if (wr_addr[ADDR_W]) begin
                    err_nx   = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    we_nx    = 1'b1;
                    wd_nx    = SENTINEL;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            state       <= S_IDLE;
            wr_addr     <= '0;
            dim         <= '0;
            row_cnt     <= '0;
            err         <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            sram_we_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_addr   <= wr_addr_nx;
            dim       <= dim_nx;
            row_cnt   <= row_cnt_nx;
            err       <= err_nx;
            sram_we_q <= we_nx;
            if (we_nx) begin
                sram_addr_q <= wr_addr[ADDR_W-1:0];
                sram_data_q <= wd_nx;
            end
        end
    end

    assign lif.in_ready           = in_ready;
    assign lif.sram_write_address = sram_addr_q;
    assign lif.sram_write_data    = sram_data_q;
    assign lif.sram_write_enable  = sram_we_q;
    assign lif.load_busy          = (state == S_HDR) || (state == S_ROW) || (state == S_TERM);
    assign lif.load_error         = err;

`ifdef IMAGE_LOADER_AUTORUN_EN
    logic term_wr_q, run_q;

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            term_wr_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            term_wr_q <= (state == S_TERM) && we_nx;
            run_q     <= term_wr_q;
        end
    end

    assign lif.run_o = run_q;
`else
    assign lif.run_o = 1'b0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - scoreboard bench for image_loader, directed scenarios on a 12-bit and a 4-bit instance
module tb_image_loader;
    import image_loader_pkg::*;

    logic clk = 1'b0;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    image_loader_if #(.ADDR_W(12), .DATA_W(16)) u_if ();
    image_loader_if #(.ADDR_W(4),  .DATA_W(16)) s_if ();

    image_loader #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .lif     (u_if)
    );

    image_loader #(.ADDR_W(4), .DATA_W(16)) dut_s (
        .clk     (clk),
        .reset_b (reset_b),
        .lif     (s_if)
    );

`ifdef IMAGE_LOADER_AUTORUN_EN
    localparam int RUN_EXP = 1;
`else
    localparam int RUN_EXP = 0;
`endif

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    wr_t         exp_q[$];
    logic [11:0] exp_addr = '0;
    int          s_writes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (u_if.sram_write_enable) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                       u_if.sram_write_address, u_if.sram_write_data);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(u_if.sram_write_address), 32'(e.addr));
                chk("write_data", 32'(u_if.sram_write_data), 32'(e.data));
            end
        end
        if (s_if.sram_write_enable) s_writes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        u_if.load_start = 1'b1;
        tick();
        u_if.load_start = 1'b0;
        exp_addr = '0;
    endtask

    // Presents one beat after `gap` idle cycles; pushes the expected write if one is due.
    task automatic send(input logic [15:0] d, input bit wr, input logic [15:0] ed, input int gap);
        int n;
        repeat (gap) tick();
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        n = 0;
        while (!u_if.in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        assert (u_if.in_ready) else begin
            errors++;
            $error("FAIL in_ready_timeout: observed 0 expected 1");
        end
        if (wr) begin
            exp_q.push_back({exp_addr, ed});
            exp_addr++;
        end
        tick();
        u_if.in_valid = 1'b0;
    endtask

    task automatic finish_with_done();
        u_if.load_done = 1'b1;
        exp_q.push_back({exp_addr, SENTINEL});
        tick();
        u_if.load_done = 1'b0;
    endtask

    task automatic send_image(input int dim, input int max_gap);
        logic [15:0] one, mask, d;
        one  = 16'h1;
        mask = (one << dim) - one;
        send(16'(dim), 1'b1, 16'(dim), $urandom_range(max_gap));
        for (int r = 0; r < dim; r++) begin
            d = 16'($urandom);
            send(d, 1'b1, d & mask, $urandom_range(max_gap));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        u_if.load_start = 1'b0; u_if.load_done = 1'b0; u_if.in_valid = 1'b0; u_if.in_data = '0;
        s_if.load_start = 1'b0; s_if.load_done = 1'b0; s_if.in_valid = 1'b0; s_if.in_data = '0;
        tick();
        tick();
        chk("rst_we",    32'(u_if.sram_write_enable), 0);
        chk("rst_addr",  32'(u_if.sram_write_address), 0);
        chk("rst_busy",  32'(u_if.load_busy), 0);
        chk("rst_error", 32'(u_if.load_error), 0);
        chk("rst_ready", 32'(u_if.in_ready), 0);
        reset_b = 1'b0;
        tick();

        // Scenario 1: one 10x10 image of all-ones rows, then terminator.
        start_session();
        chk("s1_busy", 32'(u_if.load_busy), 1);
        send(16'd10, 1'b1, 16'd10, 0);
        for (int r = 0; r < 10; r++) send(16'hFFFF, 1'b1, 16'h03FF, 0);
        finish_with_done();
        chk("s1_term_busy", 32'(u_if.load_busy), 1);
        tick();
        chk("s1_term_we",   32'(u_if.sram_write_enable), 1);
        chk("s1_term_addr", 32'(u_if.sram_write_address), 11);
        chk("s1_idle_busy", 32'(u_if.load_busy), 0);
        chk("s1_run_early", 32'(u_if.run_o), 0);
        tick();
        chk("s1_we_single", 32'(u_if.sram_write_enable), 0);
        chk("s1_run_pulse", 32'(u_if.run_o), 32'(RUN_EXP));
        tick();
        chk("s1_run_end",   32'(u_if.run_o), 0);
        chk("s1_drained",   32'(exp_q.size()), 0);

        // Scenario 2: 16x16 then 12x12 with random gaps in in_valid.
        start_session();
        send_image(16, 2);
        send_image(12, 2);
        finish_with_done();
        tick();
        chk("s2_term_addr", 32'(u_if.sram_write_address), 30);
        chk("s2_term_data", 32'(u_if.sram_write_data), 32'h00FF);
        tick();
        tick();
        chk("s2_addr_held", 32'(u_if.sram_write_address), 30);
        chk("s2_drained",   32'(exp_q.size()), 0);

        // Scenario 3: bad header, then restart clears the error.
        start_session();
        send(16'd11, 1'b0, 16'd0, 0);
        chk("s3_error", 32'(u_if.load_error), 1);
        chk("s3_ready", 32'(u_if.in_ready), 0);
        chk("s3_busy",  32'(u_if.load_busy), 0);
        tick();
        tick();
        start_session();
        chk("s3_error_clr", 32'(u_if.load_error), 0);
        chk("s3_busy_again", 32'(u_if.load_busy), 1);
        finish_with_done();
        tick();
        tick();
        tick();

        // Scenario 4: load_done after 5 of 12 rows.
        start_session();
        send(16'd12, 1'b1, 16'd12, 0);
        for (int r = 0; r < 5; r++) send(16'hABCD, 1'b1, 16'h0BCD, 1);
        u_if.load_done = 1'b1;
        tick();
        u_if.load_done = 1'b0;
        chk("s4_error", 32'(u_if.load_error), 1);
        chk("s4_busy",  32'(u_if.load_busy), 0);
        tick();
        tick();
        chk("s4_no_term", 32'(u_if.sram_write_enable), 0);
        chk("s4_drained", 32'(exp_q.size()), 0);

        // Scenario 5: 4-bit address space overflows inside a 16-row image.
        s_if.load_start = 1'b1;
        tick();
        s_if.load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = (i == 0) ? 16'd16 : 16'(i);
            checks++;
            assert (s_if.in_ready) else begin
                errors++;
                $error("FAIL s5_ready: observed 0 expected 1 at beat %0d", i);
            end
            tick();
        end
        s_if.in_valid = 1'b0;
        chk("s5_error", 32'(s_if.load_error), 1);
        chk("s5_ready", 32'(s_if.in_ready), 0);
        chk("s5_addr",  32'(s_if.sram_write_address), 15);
        tick();
        tick();
        chk("s5_writes",     32'(s_writes), 16);
        chk("s5_addr_held",  32'(s_if.sram_write_address), 15);

        // Scenario 6: asynchronous reset mid-row, then a fresh session.
        start_session();
        send(16'd12, 1'b1, 16'd12, 0);
        for (int r = 0; r < 3; r++) send(16'h1234, 1'b1, 16'h0234, 0);
        @(negedge clk);
        #2 reset_b = 1'b1;
        #1;
        chk("s6_we",    32'(u_if.sram_write_enable), 0);
        chk("s6_addr",  32'(u_if.sram_write_address), 0);
        chk("s6_data",  32'(u_if.sram_write_data), 0);
        chk("s6_busy",  32'(u_if.load_busy), 0);
        chk("s6_error", 32'(u_if.load_error), 0);
        chk("s6_run",   32'(u_if.run_o), 0);
        @(posedge clk);
        #1 reset_b = 1'b0;
        tick();
        start_session();
        send(16'd16, 1'b1, 16'd16, 0);
        tick();
        chk("s6_hdr_addr", 32'(u_if.sram_write_address), 0);
        chk("s6_drained",  32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter ADDR_W, default 12: SRAM address width.
REQ-002 Parameter DATA_W, default 16: SRAM word width; only 16 is supported.
REQ-003 Port clk  input  1: single clock; all logic on the rising edge.
REQ-004 Port reset_b  input  1: one clock; reset is asynchronous and active-high (reset_b asserted = 1).
REQ-005 Port load_start  input  1: one-cycle pulse; begins a load session at address 0.
REQ-006 Port load_done  input  1: one-cycle pulse; host has no more images; triggers the terminator write.
REQ-007 Port in_valid  input  1: host beat valid.
REQ-008 Port in_ready  output  1: loader accepts a beat when in_valid and in_ready are both 1.
REQ-009 Port in_data  input  DATA_W: header or row beat.
REQ-010 Port sram_write_address  output  ADDR_W: input-SRAM write address, registered.
REQ-011 Port sram_write_data  output  DATA_W: input-SRAM write data, registered.
REQ-012 Port sram_write_enable  output  1: input-SRAM write strobe, registered.
REQ-013 Port load_busy  output  1: session in progress.
REQ-014 Port load_error  output  1: sticky error flag.
REQ-015 Port run_o  output  1: one-cycle pulse to the convolution engine's dut_run (see Configuration).

Function
REQ-016 States: S_IDLE, S_HDR, S_ROW, S_TERM, S_ERR. State changes occur only on clock edges.
REQ-017 S_IDLE: in_ready=0. load_start -> S_HDR; write address cleared to 0; load_busy=1 from the next cycle.
REQ-018 S_HDR: in_ready = ~load_done. An accepted beat is an image header:
- in_data in {10, 12, 16}: header is written verbatim; dim is latched; row counter is set to dim; -> S_ROW.
- Any other value: no write; load_error=1; -> S_ERR.
REQ-019 S_ROW: in_ready=1. Each accepted beat is written with bits [15:dim] forced to 0. The row counter decrements; when it reaches 0 -> S_HDR.
REQ-020 Every write appears on the SRAM port exactly 1 cycle after acceptance. The address increments by 1 after each write.
REQ-021 load_done in S_HDR -> S_TERM; load_done wins over a simultaneous in_valid, and that beat is not accepted.
REQ-022 S_TERM: write 16'h00FF at the current address, then -> S_IDLE with load_busy=0.
REQ-023 load_done in S_ROW (partial image) -> S_ERR; load_error=1; no terminator is written.
REQ-024 Address overflow: if a write is required at address 2^ADDR_W-1 and another write remains (a row or the terminator), then load_error=1 and -> S_ERR. The address never wraps.
REQ-025 S_ERR: in_ready=0, load_busy=0, no writes. load_start clears load_error and restarts as in REQ-017.
REQ-026 load_start outside S_IDLE and S_ERR is ignored.
REQ-027 sram_write_enable is high for exactly one cycle per write; sram_write_data and sram_write_address are held between writes.

Reset
REQ-028 reset_b=1 forces, asynchronously:
- state=S_IDLE
- sram_write_address=0, sram_write_data=0, sram_write_enable=0
- load_busy=0, load_error=0, run_o=0
- internal counters=0
REQ-029 reset_b asserted mid-session abandons the session immediately; no terminator is written.

Configuration
REQ-030 Macro IMAGE_LOADER_AUTORUN_EN:
- Defined: run_o pulses for 1 cycle, on the cycle after the terminator write.
- Undefined: run_o is tied to 0.

Structure
REQ-031 Package image_loader_pkg holds: the state enum, DIM_10/DIM_12/DIM_16 constants, and the SENTINEL=16'h00FF constant.
REQ-032 Single module; no sub-module. Row masking is an inline function in the package.

Verification
REQ-033 Scenario 1: load_start; header 10; 10 rows of 16'hFFFF; load_done -> writes:
- addr0=10
- addr1..10=16'h03FF
- addr11=16'h00FF
- then run_o pulses once (AUTORUN_EN defined).
REQ-034 Scenario 2: headers 16 then 12, each followed by full rows, with in_valid toggled randomly -> 30 writes in order, then terminator at addr 30; no lost or duplicated beats.
REQ-035 Scenario 3: header 11 -> load_error=1, no write at addr0, in_ready=0; a later load_start clears load_error.
REQ-036 Scenario 4: load_done after 5 of 12 rows -> S_ERR, load_error=1, no 16'h00FF written.
REQ-037 Scenario 5: ADDR_W=4, header 16 -> load_error=1 when the write at address 15 is followed by a pending row; address stays at 15.
REQ-038 Scenario 6: reset_b pulsed mid-row -> all outputs 0 within the same cycle; a new session then writes its header at addr0.
